// File: rtl/draw_arbiter.sv
// Two-requester round-robin arbiter feeding a square-fill pixel engine.
// The engine streams one clipped pixel per cycle to a 160x120 VGA adapter.
module draw_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] shape0,
    input  logic [1:0] shape1,
    input  logic [7:0] ox0,
    input  logic [7:0] ox1,
    input  logic [6:0] oy0,
    input  logic [6:0] oy1,
    input  logic [2:0] col0,
    input  logic [2:0] col1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       owner
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [1:0] shape_q, shape_d;
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;
    logic [2:0] col_q, col_d;
    logic [4:0] side_q, side_d;
    logic [8:0] q_q, q_d;
    logic [4:0] dx_q, dx_d;
    logic [4:0] dy_q, dy_d;
    logic [7:0] hx_q, hx_d;
    logic [6:0] hy_q, hy_d;
    logic [2:0] hc_q, hc_d;

    logic       grant;
    logic       gnt;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       in_view;
    logic [4:0] side_sel;
    logic [8:0] q_last;

    always_comb begin
        grant = (req0 | req1) & ~reset & (state_q == IDLE);
        gnt   = (req0 & req1) ? ~last_q : req1;
    end

    // Sums are one bit wider so off-screen pixels are clipped, not wrapped.
    always_comb begin
        sum_x   = {1'b0, ox_q} + {4'b0, dx_q};
        sum_y   = {1'b0, oy_q} + {3'b0, dy_q};
        in_view = (sum_x < 9'd160) && (sum_y < 8'd120);
    end

    always_comb begin
        unique case (shape_q)
            2'b00:   begin side_sel = 5'd20; q_last = 9'd399; end
            2'b01:   begin side_sel = 5'd10; q_last = 9'd99;  end
            default: begin side_sel = 5'd4;  q_last = 9'd15;  end
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        shape_d = shape_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        col_d   = col_q;
        side_d  = side_q;
        q_d     = q_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        hc_d    = hc_q;
        ack0    = 1'b0;
        ack1    = 1'b0;
        done    = 1'b0;
        plot    = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    ack0    = ~gnt;
                    ack1    = gnt;
                    busy    = 1'b1;
                    last_d  = gnt;
                    owner_d = gnt;
                    shape_d = gnt ? shape1 : shape0;
                    ox_d    = gnt ? ox1 : ox0;
                    oy_d    = gnt ? oy1 : oy0;
                    col_d   = gnt ? col1 : col0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                q_d     = 9'd0;
                dx_d    = 5'd0;
                dy_d    = 5'd0;
                side_d  = side_sel;
                state_d = (shape_q == 2'b11) ? DONE : DRAW;
            end
            DRAW: begin
                plot = in_view;
                hx_d = sum_x[7:0];
                hy_d = sum_y[6:0];
                hc_d = col_q;
                q_d  = q_q + 9'd1;
                if (dx_q == side_q - 5'd1) begin
                    dx_d = 5'd0;
                    dy_d = dy_q + 5'd1;
                end else begin
                    dx_d = dx_q + 5'd1;
                end
                if (q_q == q_last)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Pixel bus follows the engine in DRAW and holds its last value otherwise.
    always_comb begin
        vga_x  = (state_q == DRAW) ? sum_x[7:0] : hx_q;
        vga_y  = (state_q == DRAW) ? sum_y[6:0] : hy_q;
        colour = (state_q == DRAW) ? col_q : hc_q;
        owner  = grant ? gnt : owner_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            shape_q <= 2'd0;
            ox_q    <= 8'd0;
            oy_q    <= 7'd0;
            col_q   <= 3'd0;
            side_q  <= 5'd0;
            q_q     <= 9'd0;
            dx_q    <= 5'd0;
            dy_q    <= 5'd0;
            hx_q    <= 8'd0;
            hy_q    <= 7'd0;
            hc_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            shape_q <= shape_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            col_q   <= col_d;
            side_q  <= side_d;
            q_q     <= q_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            hc_q    <= hc_d;
        end
    end

endmodule
